sgd_add_tree_acc: RTL and testbench

//  Parametrised pipelined signed adder tree with per-lane enable masking, followed by a

---
 rtl/sgd_add_tree_acc.sv | 155 +++++++++++++++
 tb/tb_sgd_add_tree_acc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_add_tree_acc.sv
// sgd_add_tree_acc: pipelined signed lane adder tree + multi-beat accumulator.
// Ports: clk, rst_n, in_data/in_en/in_valid/in_last/in_clear -> out_data/out_valid/out_beats/out_sat.
// Optional output clamp: define SGD_ADD_TREE_SAT_EN (default build wraps, out_sat=0).
module sgd_add_tree_acc #(
  parameter int NUM_IN = 8,
  parameter int IN_W   = 32,
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [NUM_IN-1:0]      in_en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   in_clear,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       out_beats,
  output logic                   out_sat
);

  localparam int LT = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // entries remaining after k pairwise levels
  function automatic int lvl_n(input int k);
    lvl_n = (NUM_IN + (1 << k) - 1) >> k;
  endfunction

  genvar k, j;
  generate
    for (k = 0; k <= LT; k++) begin : g_lv
      localparam int N = lvl_n(k);
      for (j = 0; j < N; j++) begin : g_n
        logic signed [ACC_W-1:0] q;
        if (k == 0) begin : g_in
          logic [IN_W-1:0] lane;
          assign lane = in_data[j*IN_W +: IN_W];
          assign q = in_en[j] ?
            {{(ACC_W-IN_W){lane[IN_W-1]}}, lane} : '0;
        end else begin : g_red
          localparam int NP = lvl_n(k - 1);
          if (2*j + 1 < NP) begin : g_add
            always_ff @(posedge clk or negedge rst_n) begin
              if (!rst_n) q <= '0;
              else q <= g_lv[k-1].g_n[2*j].q
                      + g_lv[k-1].g_n[2*j+1].q;
            end
          end else begin : g_pass
            always_ff @(posedge clk or negedge rst_n) begin
              if (!rst_n) q <= '0;
              else q <= g_lv[k-1].g_n[2*j].q;
            end
          end
        end
      end
    end
  endgenerate

  logic [LT-1:0] vld;
  logic [LT-1:0] lst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else if (in_clear) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld[0] <= in_valid;
      lst[0] <= in_valid & in_last;
      for (int i = 1; i < LT; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  logic signed [ACC_W-1:0] tsum;
  logic                    tv;
  logic                    tl;

  assign tsum = g_lv[LT].g_n[0].q;
  assign tv   = vld[LT-1];
  assign tl   = lst[LT-1];

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic                    first;
  logic [OUT_W-1:0]        conv_data;
  logic                    conv_sat;

  assign acc_next = (first ? '0 : acc) + tsum;
  assign cnt_next = first ? CNT_W'(1)
                  : ((cnt == '1) ? cnt : cnt + 1'b1);

`ifdef SGD_ADD_TREE_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    conv_data = acc_next[OUT_W-1:0];
    conv_sat  = 1'b0;
    if (acc_next > MAXV) begin
      conv_data = MAXV[OUT_W-1:0];
      conv_sat  = 1'b1;
    end else if (acc_next < MINV) begin
      conv_data = MINV[OUT_W-1:0];
      conv_sat  = 1'b1;
    end
  end
`else
  assign conv_data = acc_next[OUT_W-1:0];
  assign conv_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (in_clear) begin
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tv) begin
        acc <= acc_next;
        cnt <= cnt_next;
        if (tl) begin
          out_data  <= conv_data;
          out_beats <= cnt_next;
          out_sat   <= conv_sat;
          out_valid <= 1'b1;
          first     <= 1'b1;
        end else begin
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sgd_add_tree_acc.sv
// tb_sgd_add_tree_acc: scoreboard bench for sgd_add_tree_acc.
// Two instances (8 and 5 lanes); directed vectors with hand-computed sums.
module tb_sgd_add_tree_acc;

`ifdef SGD_ADD_TREE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] d8;
  logic [7:0]   e8;
  logic         v8, l8, c8;
  logic [31:0]  od8;
  logic         ov8, os8;
  logic [15:0]  ob8;

  logic [159:0] d5;
  logic [4:0]   e5;
  logic         v5, l5, c5;
  logic [31:0]  od5;
  logic         ov5, os5;
  logic [15:0]  ob5;

  sgd_add_tree_acc #(.NUM_IN(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d8), .in_en(e8), .in_valid(v8),
    .in_last(l8), .in_clear(c8),
    .out_data(od8), .out_valid(ov8),
    .out_beats(ob8), .out_sat(os8)
  );

  sgd_add_tree_acc #(.NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d5), .in_en(e5), .in_valid(v5),
    .in_last(l5), .in_clear(c5),
    .out_data(od5), .out_valid(ov5),
    .out_beats(ob5), .out_sat(os5)
  );

  typedef struct {
    logic [31:0] d;
    logic [15:0] b;
    logic        s;
    int          c;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8x, e5x;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious8: got pulse data=%h expected none", od8);
      end else begin
        e8x = q8.pop_front();
        chk("data8", 64'(od8), 64'(e8x.d));
        chk("beats8", 64'(ob8), 64'(e8x.b));
        chk("sat8", 64'(os8), 64'(e8x.s));
        chk("cycle8", 64'(cyc), 64'(e8x.c));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov5) begin
      if (q5.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious5: got pulse data=%h expected none", od5);
      end else begin
        e5x = q5.pop_front();
        chk("data5", 64'(od5), 64'(e5x.d));
        chk("beats5", 64'(ob5), 64'(e5x.b));
        chk("sat5", 64'(os5), 64'(e5x.s));
        chk("cycle5", 64'(cyc), 64'(e5x.c));
      end
    end
  end

  function automatic logic [255:0] all8(input logic [31:0] v);
    return {8{v}};
  endfunction

  task automatic drv8(input logic [255:0] d, input logic [7:0] en,
                      input logic last, input logic clr);
    @(negedge clk);
    d8 = d; e8 = en; v8 = 1'b1; l8 = last; c8 = clr;
  endtask

  task automatic idle8();
    @(negedge clk);
    v8 = 1'b0; l8 = 1'b0; c8 = 1'b0; d8 = '0; e8 = '0;
  endtask

  task automatic exp8(input logic [31:0] d, input logic [15:0] b,
                      input logic s);
    exp_t e;
    e.d = d; e.b = b; e.s = s; e.c = cyc + LAT;
    q8.push_back(e);
  endtask

  task automatic drv5(input logic [159:0] d, input logic [4:0] en,
                      input logic last);
    @(negedge clk);
    d5 = d; e5 = en; v5 = 1'b1; l5 = last; c5 = 1'b0;
  endtask

  task automatic exp5(input logic [31:0] d, input logic [15:0] b);
    exp_t e;
    e.d = d; e.b = b; e.s = 1'b0; e.c = cyc + LAT;
    q5.push_back(e);
  endtask

  initial begin
    d8 = '0; e8 = '0; v8 = 0; l8 = 0; c8 = 0;
    d5 = '0; e5 = '0; v5 = 0; l5 = 0; c5 = 0;
    repeat (2) @(negedge clk);
    chk("rst_data8", 64'(od8), 64'd0);
    chk("rst_valid8", 64'(ov8), 64'd0);
    chk("rst_beats8", 64'(ob8), 64'd0);
    chk("rst_sat8", 64'(os8), 64'd0);
    chk("rst_valid5", 64'(ov5), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: lanes 1..8 -> 36
    drv8({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
         8'hFF, 1'b1, 1'b0);
    exp8(32'd36, 16'd1, 1'b0);
    idle8();
    repeat (6) @(negedge clk);
    chk("hold_data8", 64'(od8), 64'd36);
    chk("hold_valid8", 64'(ov8), 64'd0);

    // stray last without valid must be ignored
    @(negedge clk);
    l8 = 1'b1; d8 = all8(32'd99); e8 = 8'hFF;
    idle8();

    // 2: 5 lanes, mask 10101, 3 beats -> 297
    drv5({32'd2, 32'hFFFFFFCE, 32'd100, 32'd7, 32'hFFFFFFFD},
         5'b10101, 1'b0);
    drv5({32'd2, 32'hFFFFFFCE, 32'd100, 32'd7, 32'hFFFFFFFD},
         5'b10101, 1'b0);
    drv5({32'd2, 32'hFFFFFFCE, 32'd100, 32'd7, 32'hFFFFFFFD},
         5'b10101, 1'b1);
    exp5(32'd297, 16'd3);
    @(negedge clk);
    v5 = 1'b0; l5 = 1'b0;

    // 3: back-to-back single-beat vectors
    drv8(all8(32'd10), 8'hFF, 1'b1, 1'b0);
    exp8(32'd80, 16'd1, 1'b0);
    drv8(all8(32'd20), 8'hFF, 1'b1, 1'b0);
    exp8(32'd160, 16'd1, 1'b0);
    drv8(all8(32'd30), 8'hFF, 1'b1, 1'b0);
    exp8(32'd240, 16'd1, 1'b0);
    drv8(all8(32'd40), 8'hFF, 1'b1, 1'b0);
    exp8(32'd320, 16'd1, 1'b0);
    idle8();
    repeat (5) @(negedge clk);

    // 4: clear on beat 2, then all-ones single beat -> 8
    drv8(all8(32'd3), 8'hFF, 1'b0, 1'b0);
    drv8(all8(32'd3), 8'hFF, 1'b0, 1'b1);
    drv8(all8(32'd1), 8'hFF, 1'b1, 1'b0);
    exp8(32'd8, 16'd1, 1'b0);
    idle8();
    repeat (5) @(negedge clk);

    // 5: overflow of output width
    drv8(all8(32'h7FFFFFFF), 8'hFF, 1'b0, 1'b0);
    drv8(all8(32'h7FFFFFFF), 8'hFF, 1'b1, 1'b0);
    exp8(SAT ? 32'h7FFFFFFF : 32'hFFFFFFF0, 16'd2, SAT);
    idle8();
    repeat (5) @(negedge clk);

    // 6: async reset mid-vector
    drv8(all8(32'd5), 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    v8 = 1'b0;
    #1;
    chk("arst_data8", 64'(od8), 64'd0);
    chk("arst_valid8", 64'(ov8), 64'd0);
    chk("arst_beats8", 64'(ob8), 64'd0);
    chk("arst_data5", 64'(od5), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv8(all8(32'd2), 8'hFF, 1'b1, 1'b0);
    exp8(32'd16, 16'd1, 1'b0);
    idle8();

    for (int i = 0; i < 30; i++) begin
      if (q8.size() == 0 && q5.size() == 0) break;
      @(negedge clk);
    end
    while (q8.size() > 0) begin
      e8x = q8.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing8: got no pulse expected data=%h", e8x.d);
    end
    while (q5.size() > 0) begin
      e5x = q5.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing5: got no pulse expected data=%h", e5x.d);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
